// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with dead-time blanking between digits.
// Optional leading-zero blanking is built when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan_ctrl #(
  parameter logic [15:0] CLK_DIV = 16'd200,
  parameter logic [15:0] GAP_CYC = 16'd2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [3:0] nib_i,
  input  logic [3:0] dp_in_i,
  output logic [1:0] adr_o,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       frame_o
);

  typedef enum logic [1:0] {
    S_OFF,
    S_GAP,
    S_ON
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] divCnt_q, divCnt_d;
  logic [1:0]  adr_q, adr_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_q, frame_d;
`ifdef SEG_SCAN_LZ_BLANK_EN
  logic        lz_q, lz_d;
`endif

  logic [3:0]  anSel;
  logic [6:0]  segDec;

  function automatic logic [6:0] decodeNib(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign anSel  = ~(4'b0001 << adr_q);
  assign segDec = decodeNib(nib_i);

  // nib is only sampled at the end of the gap, so the external mux has had at least one cycle to settle.
  always_comb begin
    state_d  = state_q;
    divCnt_d = divCnt_q;
    adr_d    = adr_q;
    an_d     = an_q;
    seg_d    = seg_q;
    dp_d     = dp_q;
    frame_d  = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
    lz_d     = lz_q;
`endif

    if (!en_i) begin
      state_d  = S_OFF;
      divCnt_d = 16'd0;
      adr_d    = 2'd3;
      an_d     = 4'hF;
      seg_d    = 7'h7F;
      dp_d     = 1'b1;
`ifdef SEG_SCAN_LZ_BLANK_EN
      lz_d     = 1'b1;
`endif
    end else begin
      case (state_q)
        S_OFF: begin
          state_d  = S_GAP;
          divCnt_d = 16'd0;
`ifdef SEG_SCAN_LZ_BLANK_EN
          lz_d     = 1'b1;
`endif
        end

        S_GAP: begin
          divCnt_d = divCnt_q + 16'd1;
          if (divCnt_q == GAP_CYC - 16'd1) begin
            state_d = S_ON;
            seg_d   = segDec;
            dp_d    = ~dp_in_i[adr_q];
            an_d    = anSel;
`ifdef SEG_SCAN_LZ_BLANK_EN
            // A blanked leading zero keeps its anode off unless its decimal point must still be shown.
            if (lz_q && (nib_i == 4'h0) && (adr_q != 2'd0)) begin
              seg_d = 7'h7F;
              if (!dp_in_i[adr_q]) an_d = 4'hF;
            end else begin
              lz_d = 1'b0;
            end
`endif
          end
        end

        S_ON: begin
          divCnt_d = divCnt_q + 16'd1;
          if (divCnt_q == CLK_DIV - 16'd1) begin
            state_d  = S_GAP;
            divCnt_d = 16'd0;
            an_d     = 4'hF;
            adr_d    = adr_q - 2'd1;
            if (adr_q == 2'd0) begin
              frame_d = 1'b1;
`ifdef SEG_SCAN_LZ_BLANK_EN
              lz_d    = 1'b1;
`endif
            end
          end
        end

        default: begin
          state_d  = S_OFF;
          divCnt_d = 16'd0;
          adr_d    = 2'd3;
          an_d     = 4'hF;
          seg_d    = 7'h7F;
          dp_d     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_OFF;
      divCnt_q <= 16'd0;
      adr_q    <= 2'd3;
      an_q     <= 4'hF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
      lz_q     <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      divCnt_q <= divCnt_d;
      adr_q    <= adr_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
`ifdef SEG_SCAN_LZ_BLANK_EN
      lz_q     <= lz_d;
`endif
    end
  end

  assign adr_o   = adr_q;
  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected lit digits are queued per scenario and compared
// against each lit run observed on the anode/segment pins (CLK_DIV=8, GAP_CYC=2).
module tb_seg_scan_ctrl;

  localparam logic [15:0] CLK_DIV = 16'd8;
  localparam logic [15:0] GAP_CYC = 16'd2;
  localparam int LIT = 6;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  dpIn = 4'h0;
  logic [15:0] muxVal = 16'h12AF;
  logic [3:0]  nib;
  logic [1:0]  adr;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  int checkCnt = 0;
  int passCnt = 0;
  int cycleCnt = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         len;
    int         gap;
    bit         stable;
  } run_t;

  run_t runs[$];
  run_t expQ[$];
  int   frames[$];

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .nib_i(nib), .dp_in_i(dpIn),
    .adr_o(adr), .an_o(an), .seg_o(seg), .dp_o(dp), .frame_o(frame)
  );

  // External 16-to-4 nibble mux, combinational like the board.
  assign nib = muxVal[{adr, 2'b00} +: 4];

  always #5 clk = ~clk;
  always @(negedge clk) cycleCnt <= cycleCnt + 1;

  function automatic void pushExp(input logic [3:0] a, input logic [6:0] s, input logic d,
                                  input int g);
    run_t r;
    r.an = a; r.seg = s; r.dp = d; r.len = LIT; r.gap = g; r.stable = 1'b1;
    expQ.push_back(r);
  endfunction

  // Records each lit run: value at its first cycle, length, blank cycles before it, and stability.
  task automatic captureRuns(input int nRuns, input int maxCycles);
    run_t cur;
    bit inRun = 0;
    int gapCnt = 0;
    runs.delete();
    frames.delete();
    cur.an = 4'hF; cur.seg = 7'h7F; cur.dp = 1'b1; cur.len = 0; cur.gap = 0; cur.stable = 1'b1;
    for (int c = 0; c < maxCycles && runs.size() < nRuns; c++) begin
      @(negedge clk);
      if (frame === 1'b1) frames.push_back(cycleCnt);
      if (an !== 4'hF) begin
        if (!inRun) begin
          cur.an = an; cur.seg = seg; cur.dp = dp; cur.len = 0; cur.gap = gapCnt; cur.stable = 1'b1;
          inRun = 1;
        end else if (an !== cur.an || seg !== cur.seg || dp !== cur.dp) begin
          cur.stable = 1'b0;
        end
        cur.len++;
      end else begin
        if (inRun) begin
          runs.push_back(cur);
          inRun = 0;
          gapCnt = 0;
        end
        gapCnt++;
      end
    end
  endtask

  // en is raised at a falling edge; the first captured run then sees GAP blank samples.
  task automatic restartScan(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    muxVal = v;
    dpIn = d;
    en = 1'b1;
  endtask

  task automatic test_reset();
    int k = 0;
    int offCnt = 0;
    bit adrOk = 1;
    repeat (3) @(negedge clk);
    checkCnt++;
    if (an !== 4'hF) $display("[TB] FAIL reset_an: got %h want F", an); else passCnt++;
    checkCnt++;
    if (seg !== 7'h7F) $display("[TB] FAIL reset_seg: got %h want 7F", seg); else passCnt++;
    checkCnt++;
    if (dp !== 1'b1) $display("[TB] FAIL reset_dp: got %b want 1", dp); else passCnt++;
    checkCnt++;
    if (adr !== 2'd3) $display("[TB] FAIL reset_adr: got %0d want 3", adr); else passCnt++;
    checkCnt++;
    if (frame !== 1'b0) $display("[TB] FAIL reset_frame: got %b want 0", frame); else passCnt++;
    rst_n = 1'b1;
    do begin
      @(negedge clk);
      k++;
      if (an === 4'hF) begin
        offCnt++;
        if (adr !== 2'd3) adrOk = 0;
      end
    end while (an === 4'hF && k < 20);
    // The release cycle itself is blank too, giving 1+GAP blank cycles in total.
    checkCnt++;
    if (offCnt != GAP) $display("[TB] FAIL reset_blank_len: got %0d want %0d", offCnt + 1, GAP + 1);
    else passCnt++;
    checkCnt++;
    if (!adrOk) $display("[TB] FAIL reset_adr_hold: got adr change want 3"); else passCnt++;
    checkCnt++;
    if ({an, seg} !== {4'h7, 7'h79}) $display("[TB] FAIL reset_first_lit: got an=%h seg=%h want an=7 seg=79", an, seg);
    else passCnt++;
  endtask

  task automatic test_scan();
    run_t e;
    expQ.delete();
    for (int f = 0; f < 2; f++) begin
      pushExp(4'h7, 7'h79, 1'b1, GAP);
      pushExp(4'hB, 7'h24, 1'b1, GAP);
      pushExp(4'hD, 7'h08, 1'b1, GAP);
      pushExp(4'hE, 7'h0E, 1'b1, GAP);
    end
    restartScan(16'h12AF, 4'h0);
    captureRuns(8, 8 * 4 * CLK_DIV + 50);
    checkCnt++;
    if (runs.size() != 8) $display("[TB] FAIL scan_count: got %0d runs want 8", runs.size()); else passCnt++;
    for (int i = 0; i < runs.size() && expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      checkCnt++;
      if ({runs[i].an, runs[i].seg, runs[i].dp} !== {e.an, e.seg, e.dp})
        $display("[TB] FAIL scan_run%0d: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 i, runs[i].an, runs[i].seg, runs[i].dp, e.an, e.seg, e.dp);
      else passCnt++;
      checkCnt++;
      if (runs[i].len != e.len || runs[i].stable !== 1'b1 || runs[i].gap != e.gap)
        $display("[TB] FAIL scan_timing%0d: got len=%0d gap=%0d stable=%b want len=%0d gap=%0d stable=1",
                 i, runs[i].len, runs[i].gap, runs[i].stable, e.len, e.gap);
      else passCnt++;
    end
    checkCnt++;
    if (frames.size() != 2) $display("[TB] FAIL scan_frame_count: got %0d want 2", frames.size());
    else passCnt++;
    if (frames.size() >= 2) begin
      checkCnt++;
      if (frames[1] - frames[0] != 4 * CLK_DIV)
        $display("[TB] FAIL scan_frame_period: got %0d want %0d", frames[1] - frames[0], 4 * CLK_DIV);
      else passCnt++;
    end
  endtask

  task automatic test_dp();
    run_t e;
    expQ.delete();
    pushExp(4'h7, 7'h79, 1'b1, GAP);
    pushExp(4'hB, 7'h24, 1'b0, GAP);
    pushExp(4'hD, 7'h08, 1'b1, GAP);
    pushExp(4'hE, 7'h0E, 1'b1, GAP);
    restartScan(16'h12AF, 4'b0100);
    captureRuns(4, 4 * CLK_DIV + 50);
    checkCnt++;
    if (runs.size() != 4) $display("[TB] FAIL dp_count: got %0d runs want 4", runs.size()); else passCnt++;
    for (int i = 0; i < runs.size() && expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      checkCnt++;
      if ({runs[i].an, runs[i].seg, runs[i].dp, runs[i].stable} !== {e.an, e.seg, e.dp, 1'b1})
        $display("[TB] FAIL dp_run%0d: got an=%h seg=%h dp=%b stable=%b want an=%h seg=%h dp=%b",
                 i, runs[i].an, runs[i].seg, runs[i].dp, runs[i].stable, e.an, e.seg, e.dp);
      else passCnt++;
    end
  endtask

  task automatic test_midslot_nib();
    run_t e;
    int k = 0;
    bit glitch = 0;
    restartScan(16'h12AF, 4'h0);
    do begin @(negedge clk); k++; end while (an !== 4'hB && k < 100);
    checkCnt++;
    if (an !== 4'hB) $display("[TB] FAIL mid_wait: got an=%h want B", an); else passCnt++;
    repeat (2) @(negedge clk);
    muxVal = 16'h15AF;
    k = 0;
    while (an === 4'hB && k < 10) begin
      if (seg !== 7'h24) glitch = 1;
      @(negedge clk);
      k++;
    end
    checkCnt++;
    if (glitch || k != LIT - 2) $display("[TB] FAIL mid_hold: got glitch=%b remaining=%0d want glitch=0 remaining=%0d", glitch, k, LIT - 2);
    else passCnt++;
    expQ.delete();
    pushExp(4'hD, 7'h08, 1'b1, -1);
    pushExp(4'hE, 7'h0E, 1'b1, GAP);
    pushExp(4'h7, 7'h79, 1'b1, GAP);
    pushExp(4'hB, 7'h12, 1'b1, GAP);
    captureRuns(4, 4 * CLK_DIV + 50);
    checkCnt++;
    if (runs.size() != 4) $display("[TB] FAIL mid_count: got %0d runs want 4", runs.size()); else passCnt++;
    for (int i = 0; i < runs.size() && expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      checkCnt++;
      if ({runs[i].an, runs[i].seg, runs[i].stable} !== {e.an, e.seg, 1'b1} || (e.gap >= 0 && runs[i].gap != e.gap))
        $display("[TB] FAIL mid_run%0d: got an=%h seg=%h gap=%0d want an=%h seg=%h gap=%0d",
                 i, runs[i].an, runs[i].seg, runs[i].gap, e.an, e.seg, e.gap);
      else passCnt++;
    end
  endtask

  task automatic test_en_drop();
    run_t e;
    int k = 0;
    restartScan(16'h12AF, 4'b0010);
    do begin @(negedge clk); k++; end while (an !== 4'hD && k < 100);
    checkCnt++;
    if (an !== 4'hD || dp !== 1'b0) $display("[TB] FAIL drop_wait: got an=%h dp=%b want an=D dp=0", an, dp);
    else passCnt++;
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checkCnt++;
    if ({an, seg} !== {4'hF, 7'h7F}) $display("[TB] FAIL drop_blank: got an=%h seg=%h want an=F seg=7F", an, seg);
    else passCnt++;
    checkCnt++;
    if ({adr, dp} !== {2'd3, 1'b1}) $display("[TB] FAIL drop_adr_dp: got adr=%0d dp=%b want adr=3 dp=1", adr, dp);
    else passCnt++;
    @(negedge clk);
    en = 1'b1;
    expQ.delete();
    pushExp(4'h7, 7'h79, 1'b1, GAP);
    captureRuns(1, CLK_DIV + 20);
    checkCnt++;
    if (runs.size() != 1) $display("[TB] FAIL drop_restart_count: got %0d runs want 1", runs.size());
    else passCnt++;
    if (runs.size() > 0) begin
      e = expQ.pop_front();
      checkCnt++;
      if ({runs[0].an, runs[0].seg, runs[0].dp} !== {e.an, e.seg, e.dp} || runs[0].gap != e.gap)
        $display("[TB] FAIL drop_restart: got an=%h seg=%h dp=%b gap=%0d want an=%h seg=%h dp=%b gap=%0d",
                 runs[0].an, runs[0].seg, runs[0].dp, runs[0].gap, e.an, e.seg, e.dp, e.gap);
      else passCnt++;
    end
    checkCnt++;
    if (frames.size() != 0) $display("[TB] FAIL drop_no_frame: got %0d pulses want 0", frames.size());
    else passCnt++;
  endtask

  task automatic test_async_reset();
    int k = 0;
    restartScan(16'h12AF, 4'b0100);
    do begin @(negedge clk); k++; end while (an !== 4'hB && k < 100);
    #2;
    rst_n = 1'b0;
    #1;
    checkCnt++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1})
      $display("[TB] FAIL areset_outputs: got an=%h seg=%h dp=%b want an=F seg=7F dp=1", an, seg, dp);
    else passCnt++;
    checkCnt++;
    if ({adr, frame} !== {2'd3, 1'b0}) $display("[TB] FAIL areset_adr: got adr=%0d frame=%b want adr=3 frame=0", adr, frame);
    else passCnt++;
    @(negedge clk);
    dpIn = 4'h0;
    rst_n = 1'b1;
    captureRuns(1, CLK_DIV + 20);
    checkCnt++;
    if (runs.size() != 1 || {runs[0].an, runs[0].seg} !== {4'h7, 7'h79} || runs[0].gap != GAP)
      $display("[TB] FAIL areset_restart: got runs=%0d want one run an=7 seg=79 gap=%0d", runs.size(), GAP);
    else passCnt++;
  endtask

`ifdef SEG_SCAN_LZ_BLANK_EN
  task automatic test_lz();
    run_t e;
    // 16'h0500: digit 3 blanked for a whole slot, then 5,0,0 shown.
    expQ.delete();
    pushExp(4'hB, 7'h12, 1'b1, CLK_DIV + GAP);
    pushExp(4'hD, 7'h40, 1'b1, GAP);
    pushExp(4'hE, 7'h40, 1'b1, GAP);
    pushExp(4'hB, 7'h12, 1'b1, CLK_DIV + GAP);
    restartScan(16'h0500, 4'h0);
    captureRuns(4, 8 * CLK_DIV + 50);
    checkCnt++;
    if (runs.size() != 4) $display("[TB] FAIL lz_count: got %0d runs want 4", runs.size()); else passCnt++;
    for (int i = 0; i < runs.size() && expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      checkCnt++;
      if ({runs[i].an, runs[i].seg, runs[i].dp} !== {e.an, e.seg, e.dp} || runs[i].gap != e.gap || runs[i].len != e.len)
        $display("[TB] FAIL lz_run%0d: got an=%h seg=%h gap=%0d len=%0d want an=%h seg=%h gap=%0d len=%0d",
                 i, runs[i].an, runs[i].seg, runs[i].gap, runs[i].len, e.an, e.seg, e.gap, e.len);
      else passCnt++;
    end
    // 16'h0000: only digit 0 lights, once per full frame.
    expQ.delete();
    pushExp(4'hE, 7'h40, 1'b1, 3 * CLK_DIV + GAP);
    pushExp(4'hE, 7'h40, 1'b1, 3 * CLK_DIV + GAP);
    // 16'h0000 with dp on digit 3: its anode is driven with a blank pattern.
    pushExp(4'h7, 7'h7F, 1'b0, GAP);
    pushExp(4'hE, 7'h40, 1'b1, 2 * CLK_DIV + GAP);
    restartScan(16'h0000, 4'h0);
    captureRuns(2, 8 * CLK_DIV + 50);
    restartScan(16'h0000, 4'b1000);
    begin
      run_t saved[$];
      saved = runs;
      captureRuns(2, 4 * CLK_DIV + 50);
      runs = {saved, runs};
    end
    checkCnt++;
    if (runs.size() != 4) $display("[TB] FAIL lz_zero_count: got %0d runs want 4", runs.size()); else passCnt++;
    for (int i = 0; i < runs.size() && expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      checkCnt++;
      if ({runs[i].an, runs[i].seg, runs[i].dp} !== {e.an, e.seg, e.dp} || runs[i].gap != e.gap)
        $display("[TB] FAIL lz_zero_run%0d: got an=%h seg=%h dp=%b gap=%0d want an=%h seg=%h dp=%b gap=%0d",
                 i, runs[i].an, runs[i].seg, runs[i].dp, runs[i].gap, e.an, e.seg, e.dp, e.gap);
      else passCnt++;
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    muxVal = 16'h12AF;
    dpIn = 4'h0;
    test_reset();
    test_scan();
    test_dp();
    test_midslot_nib();
    test_en_drop();
    test_async_reset();
`ifdef SEG_SCAN_LZ_BLANK_EN
    test_lz();
`endif
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
